// File: rtl/seg7_scan_display.sv
// seg7_scan_display: 4-digit multiplexed common-anode hex display with frame snapshot,
// leading-zero blanking and whole-display blink while the wrap flag is set.
module seg7_scan_display #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        flag,
    input  logic        blank_lz,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        frame_start
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [15:0]   r_val;
    logic          r_blz;
    logic [3:0]    r_dp;
    logic [BW-1:0] r_bcnt;
    logic          r_ph;
    logic          r_hide;
    logic          w_tick;
    logic          w_snap;
    logic [1:0]    w_nidx;
    logic [15:0]   w_val;
    logic          w_blz;
    logic [3:0]    w_dp;
    logic          w_hide;
    logic [3:0]    w_nib;
    logic          w_blank;
    logic [BW-1:0] w_bcnt_inc;
    logic          w_bwrap;
    // The digit shown first in a new frame is decoded from the live inputs, so
    // every source below falls through to them on the snapshot edge.
    always_comb begin
        w_tick     = r_presc == PW'(REFRESH_DIV - 1);
        w_snap     = w_tick && r_idx == 2'd3;
        w_nidx     = r_idx + 2'd1;
        w_val      = w_snap ? value : r_val;
        w_blz      = w_snap ? blank_lz : r_blz;
        w_dp       = w_snap ? dp_in : r_dp;
        w_hide     = w_snap ? (flag & r_ph) : r_hide;
        w_nib      = w_val[{w_nidx, 2'b00} +: 4];
        w_blank    = w_blz && (w_nidx == 2'd1 ? w_val[15:4] == 12'd0 :
                               w_nidx == 2'd2 ? w_val[15:8] == 8'd0 :
                               w_nidx == 2'd3 ? w_val[15:12] == 4'd0 : 1'b0);
        w_bcnt_inc = r_bcnt + 1'b1;
        w_bwrap    = w_bcnt_inc == BW'(BLINK_FRAMES);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc     <= '0;
            r_idx       <= 2'd3;
            r_val       <= '0;
            r_blz       <= 1'b0;
            r_dp        <= '0;
            r_bcnt      <= '0;
            r_ph        <= 1'b0;
            r_hide      <= 1'b0;
            an          <= 4'hF;
            seg         <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            r_presc     <= w_tick ? '0 : r_presc + 1'b1;
            frame_start <= w_snap;
            if (w_tick) begin
                r_idx <= w_nidx;
                an    <= w_hide ? 4'hF : ~(4'b0001 << w_nidx);
                seg   <= {~w_dp[w_nidx], w_blank ? 7'h7F : ~FONT[w_nib]};
            end
            // Visibility of a frame uses the phase held before this frame is counted.
            if (w_snap) begin
                r_val  <= value;
                r_blz  <= blank_lz;
                r_dp   <= dp_in;
                r_hide <= flag & r_ph;
                r_bcnt <= (!flag || w_bwrap) ? '0 : w_bcnt_inc;
                r_ph   <= flag && (r_ph ^ w_bwrap);
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: directed frames pushed to a scoreboard queue; a monitor
// checks each queued frame digit by digit starting at frame_start.
module tb_seg7_scan_display;
    typedef struct {
        logic [31:0] seg;
        logic        hide;
        int          id;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = 16'h1A0F;
    logic        flag = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_start;
    frame_t      q[$];
    int          checks = 0;
    int          errors = 0;
    int          next_id = 0;
    logic [3:0]  an_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    seg7_scan_display #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .flag(flag), .blank_lz(blank_lz),
        .dp_in(dp_in), .an(an), .seg(seg), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_fs();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_start) return;
        end
        chk("frame_start_timeout", 32'd0, 32'd1);
    endtask

    task automatic step(input int d, input logic [15:0] v, input logic f, input logic b,
                        input logic [3:0] dp, input logic [31:0] exp_seg, input logic hide);
        frame_t e;
        wait_fs();
        repeat (d) @(negedge clk);
        value = v; flag = f; blank_lz = b; dp_in = dp;
        e.seg = exp_seg; e.hide = hide; e.id = next_id++;
        q.push_back(e);
    endtask

    initial begin
        frame_t e;
        forever begin
            @(negedge clk);
            if (frame_start && q.size() > 0) begin
                e = q.pop_front();
                for (int k = 0; k < 4; k++) begin
                    if (k == 1) begin
                        @(negedge clk);
                        chk($sformatf("f%0d_fs_pulse", e.id), {31'd0, frame_start}, 32'd0);
                        repeat (3) @(negedge clk);
                    end else if (k > 1) begin
                        repeat (4) @(negedge clk);
                    end
                    chk($sformatf("f%0d_an%0d", e.id, k), {28'd0, an}, {28'd0, e.hide ? 4'hF : an_exp[k]});
                    chk($sformatf("f%0d_seg%0d", e.id, k), {24'd0, seg}, {24'd0, e.seg[k*8 +: 8]});
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {24'd0, seg}, 32'hFF);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk($sformatf("hold_an_%0d", i), {28'd0, an}, 32'hF);
            chk($sformatf("hold_seg_%0d", i), {24'd0, seg}, 32'hFF);
        end
        @(negedge clk);
        chk("first_an", {28'd0, an}, 32'hE);
        chk("first_fs", {31'd0, frame_start}, 32'd1);
        chk("first_seg", {24'd0, seg}, 32'h8E);
        @(negedge clk);
        chk("first_fs_end", {31'd0, frame_start}, 32'd0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_an", {28'd0, an}, 32'hF);
        chk("async_rst_seg", {24'd0, seg}, 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        // scan order, repeated
        step(1, 16'h1A0F, 1'b0, 1'b0, 4'h0, 32'hF9_88_C0_8E, 1'b0);
        step(1, 16'h1A0F, 1'b0, 1'b0, 4'h0, 32'hF9_88_C0_8E, 1'b0);
        // tearing: change lands while digit 1 is lit
        step(1, 16'h1234, 1'b0, 1'b0, 4'h0, 32'hF9_A4_B0_99, 1'b0);
        step(5, 16'h5678, 1'b0, 1'b0, 4'h0, 32'h92_82_F8_80, 1'b0);
        // leading-zero blanking
        step(1, 16'h0005, 1'b0, 1'b1, 4'h0, 32'hFF_FF_FF_92, 1'b0);
        step(1, 16'h0000, 1'b0, 1'b1, 4'h0, 32'hFF_FF_FF_C0, 1'b0);
        step(1, 16'h0105, 1'b0, 1'b1, 4'h0, 32'hFF_F9_C0_92, 1'b0);
        step(1, 16'h1000, 1'b0, 1'b1, 4'h0, 32'hF9_C0_C0_C0, 1'b0);
        // decimal point, with and without blanking
        step(1, 16'h0000, 1'b0, 1'b0, 4'b0100, 32'hC0_40_C0_C0, 1'b0);
        step(1, 16'h0000, 1'b0, 1'b1, 4'b1000, 32'h7F_FF_FF_C0, 1'b0);
        // blink: two visible, two hidden, two visible, then drop flag in a hidden frame
        step(1, 16'h1A0F, 1'b1, 1'b0, 4'h0, 32'hF9_88_C0_8E, 1'b0);
        step(1, 16'h1A0F, 1'b1, 1'b0, 4'h0, 32'hF9_88_C0_8E, 1'b0);
        step(1, 16'h1A0F, 1'b1, 1'b0, 4'h0, 32'hF9_88_C0_8E, 1'b1);
        step(1, 16'h1A0F, 1'b1, 1'b0, 4'h0, 32'hF9_88_C0_8E, 1'b1);
        step(1, 16'h1A0F, 1'b1, 1'b0, 4'h0, 32'hF9_88_C0_8E, 1'b0);
        step(1, 16'h1A0F, 1'b1, 1'b0, 4'h0, 32'hF9_88_C0_8E, 1'b0);
        step(1, 16'h1A0F, 1'b1, 1'b0, 4'h0, 32'hF9_88_C0_8E, 1'b1);
        step(1, 16'h1A0F, 1'b0, 1'b0, 4'h0, 32'hF9_88_C0_8E, 1'b0);
        step(1, 16'h1A0F, 1'b0, 1'b0, 4'h0, 32'hF9_88_C0_8E, 1'b0);
        wait_fs();
        wait_fs();
        repeat (20) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
